// File: rtl/player_kinematics.sv
// player_kinematics: frame-ticked per-player motion engine covering horizontal stepping, jump, gravity, ceiling and floor.
// Air jumps (up to MAX_JUMPS before landing) are enabled by defining PLAYER_MULTI_JUMP_EN.
module player_kinematics #(
    parameter int POS_W     = 11,
    parameter int VEL_W     = 8,
    parameter int STEP_X    = 5,
    parameter int G         = 1,
    parameter int V         = 10,
    parameter int V_TERM    = 10,
    parameter int MAX_J     = 20,
    parameter int MAX_JUMPS = 2,
    parameter int LIMIT_X   = 10,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 400,
    parameter int INIT_X    = 100
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_tick,
    input  logic                               i_left,
    input  logic                               i_right,
    input  logic                               i_jump,
    output logic [POS_W-1:0]                   o_x,
    output logic [POS_W-1:0]                   o_y,
    output logic signed [VEL_W-1:0]            o_vy,
    output logic [1:0]                         o_state,
    output logic [$clog2(MAX_JUMPS+1)-1:0]     o_jumps_left
);

    localparam int JL_W  = $clog2(MAX_JUMPS + 1);
    localparam int CNT_W = $clog2(MAX_J + 1);
    localparam int XW    = POS_W + 1;
    localparam int SW    = ((POS_W > VEL_W) ? POS_W : VEL_W) + 2;

`ifdef PLAYER_MULTI_JUMP_EN
    localparam int JUMPS_EFF = MAX_JUMPS;
    localparam bit AIR_JUMP  = 1'b1;
`else
    localparam int JUMPS_EFF = 1;
    localparam bit AIR_JUMP  = 1'b0;
`endif

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10
    } state_t;

    localparam logic [JL_W-1:0]         JUMPS_INIT = JL_W'(JUMPS_EFF);
    localparam logic [JL_W-1:0]         JL_ONE     = JL_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX    = CNT_W'(MAX_J);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic [XW-1:0]           X_LO       = XW'(LIMIT_X);
    localparam logic [XW-1:0]           X_HI       = XW'(X_MAX - LIMIT_X);
    localparam logic [XW-1:0]           STEP_E     = XW'(STEP_X);
    localparam logic [POS_W-1:0]        X_INIT     = POS_W'(INIT_X);
    localparam logic [POS_W-1:0]        Y_JUMP     = POS_W'(V);
    localparam logic [POS_W-1:0]        Y_CEIL     = POS_W'(Y_MAX);
    localparam logic signed [SW-1:0]    Y_TOP      = SW'(Y_MAX);
    localparam logic signed [SW-1:0]    SUM_ZERO   = SW'(0);
    localparam logic signed [VEL_W-1:0] VY_JUMP    = VEL_W'(V - G);
    localparam logic signed [VEL_W-1:0] G_V        = VEL_W'(G);
    localparam logic signed [VEL_W-1:0] VY_MIN     = VEL_W'(-V_TERM);
    localparam logic signed [VEL_W-1:0] VY_ZERO    = VEL_W'(0);

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic [POS_W-1:0]          x_r;
    logic [POS_W-1:0]          x_nxt_s;
    logic [POS_W-1:0]          y_r;
    logic [POS_W-1:0]          y_nxt_s;
    logic signed [VEL_W-1:0]   vy_r;
    logic signed [VEL_W-1:0]   vy_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [CNT_W-1:0]          cnt_nxt_s;
    logic [JL_W-1:0]           jl_r;
    logic [JL_W-1:0]           jl_nxt_s;
    logic                      req_r;
    logic                      jump_prev_r;

    logic                      jump_edge_s;
    logic                      req_s;
    logic                      accept_s;
    logic [XW-1:0]             x_ext_s;
    logic [XW-1:0]             x_inc_s;
    logic signed [SW-1:0]      y_ext_s;
    logic signed [SW-1:0]      vy_ext_s;
    logic signed [SW-1:0]      sum_s;
    logic signed [VEL_W-1:0]   vy_dec_s;
    logic [CNT_W-1:0]          cnt_inc_s;

    // Jump request: an edge seen this cycle counts for a tick in the same cycle.
    always_comb begin
        jump_edge_s = i_jump & ~jump_prev_r;
        req_s       = req_r | jump_edge_s;
    end

    // Sticky jump latch, cleared by every tick whether or not the jump is taken.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            jump_prev_r <= 1'b0;
            req_r       <= 1'b0;
        end else begin
            jump_prev_r <= i_jump;
            req_r       <= i_tick ? 1'b0 : req_s;
        end
    end

    // Horizontal stepping with margin saturation, one bit wider to avoid wrap.
    always_comb begin
        x_ext_s = {1'b0, x_r};
        x_inc_s = x_ext_s + STEP_E;
        x_nxt_s = x_r;
        if (i_left && !i_right) begin
            if (x_ext_s < (X_LO + STEP_E)) begin
                x_nxt_s = X_LO[POS_W-1:0];
            end else begin
                x_nxt_s = x_r - STEP_E[POS_W-1:0];
            end
        end else if (i_right && !i_left) begin
            if (x_inc_s > X_HI) begin
                x_nxt_s = X_HI[POS_W-1:0];
            end else begin
                x_nxt_s = x_inc_s[POS_W-1:0];
            end
        end else begin
            x_nxt_s = x_r;
        end
    end

    // Vertical next-state: jump accept beats floor/ceiling, which beat plain integration.
    always_comb begin
        y_ext_s     = {{(SW-POS_W){1'b0}}, y_r};
        vy_ext_s    = SW'(vy_r);
        sum_s       = y_ext_s + vy_ext_s;
        vy_dec_s    = vy_r - G_V;
        cnt_inc_s   = cnt_r + CNT_ONE;
        accept_s    = req_s && (jl_r != '0) && ((state_r == GROUND) || AIR_JUMP);
        state_nxt_s = state_r;
        y_nxt_s     = y_r;
        vy_nxt_s    = vy_r;
        cnt_nxt_s   = cnt_r;
        jl_nxt_s    = jl_r;
        if (!i_tick) begin
            state_nxt_s = state_r;
        end else if (accept_s) begin
            state_nxt_s = RISE;
            y_nxt_s     = y_r + Y_JUMP;
            vy_nxt_s    = VY_JUMP;
            cnt_nxt_s   = CNT_ONE;
            jl_nxt_s    = jl_r - JL_ONE;
        end else begin
            case (state_r)
                GROUND: begin
                    state_nxt_s = GROUND;
                    y_nxt_s     = '0;
                    vy_nxt_s    = VY_ZERO;
                end
                RISE, FALL: begin
                    if (sum_s <= SUM_ZERO) begin
                        state_nxt_s = GROUND;
                        y_nxt_s     = '0;
                        vy_nxt_s    = VY_ZERO;
                        cnt_nxt_s   = '0;
                        jl_nxt_s    = JUMPS_INIT;
                    end else if (sum_s >= Y_TOP) begin
                        state_nxt_s = FALL;
                        y_nxt_s     = Y_CEIL;
                        vy_nxt_s    = VY_ZERO;
                    end else if (state_r == RISE) begin
                        y_nxt_s   = sum_s[POS_W-1:0];
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_MAX) begin
                            state_nxt_s = FALL;
                            vy_nxt_s    = VY_ZERO;
                        end else if (vy_dec_s <= VY_ZERO) begin
                            state_nxt_s = FALL;
                            vy_nxt_s    = vy_dec_s;
                        end else begin
                            state_nxt_s = RISE;
                            vy_nxt_s    = vy_dec_s;
                        end
                    end else begin
                        state_nxt_s = FALL;
                        y_nxt_s     = sum_s[POS_W-1:0];
                        if (vy_dec_s < VY_MIN) begin
                            vy_nxt_s = VY_MIN;
                        end else begin
                            vy_nxt_s = vy_dec_s;
                        end
                    end
                end
                default: begin
                    state_nxt_s = GROUND;
                    y_nxt_s     = '0;
                    vy_nxt_s    = VY_ZERO;
                    cnt_nxt_s   = '0;
                    jl_nxt_s    = JUMPS_INIT;
                end
            endcase
        end
    end

    // Motion state register; x only moves on ticks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= GROUND;
            x_r     <= X_INIT;
            y_r     <= '0;
            vy_r    <= VY_ZERO;
            cnt_r   <= '0;
            jl_r    <= JUMPS_INIT;
        end else begin
            state_r <= state_nxt_s;
            x_r     <= i_tick ? x_nxt_s : x_r;
            y_r     <= y_nxt_s;
            vy_r    <= vy_nxt_s;
            cnt_r   <= cnt_nxt_s;
            jl_r    <= jl_nxt_s;
        end
    end

    // Outputs come straight from the state flops.
    always_comb begin
        o_x          = x_r;
        o_y          = y_r;
        o_vy         = vy_r;
        o_state      = state_r;
        o_jumps_left = jl_r;
    end

endmodule
